// File: rtl/window_accumulator.sv
// Window accumulator: sums K consecutive (W+1)-bit adder results and presents
// each window total on a registered valid/ready output with no inter-window bubble.
module window_accumulator #(
    parameter int W  = 4,
    parameter int K  = 9,
    parameter int AW = W + 1 + $clog2(K)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_sum,
    input  logic                   in_cout,
    input  logic                   in_clr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AW-1:0]          out_data,
    output logic [$clog2(K+1)-1:0] out_cnt
);
    localparam int CW = $clog2(K + 1);

    logic [AW-1:0] acc_p0;
    logic [CW-1:0] cnt_p0;
    logic [AW-1:0] out_data_p1;
    logic          vld_p1;

    logic          accept;
    logic          last;
    logic [AW-1:0] sample;
    logic [AW-1:0] base;
    logic [AW-1:0] total;
    logic [CW-1:0] cnt_base;

    // Stage p0: sample acceptance and partial-sum update
    assign in_ready = !(vld_p1 && !out_ready);
    assign accept   = in_valid && in_ready;
    assign sample   = {{(AW-W-1){1'b0}}, in_cout, in_sum};
    // A clear folds into the same adder: the sample then opens a fresh window.
    assign base     = in_clr ? '0 : acc_p0;
    assign cnt_base = in_clr ? '0 : cnt_p0;
    assign total    = base + sample;
    assign last     = accept && !in_clr && (cnt_p0 == CW'(K - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_p0 <= '0;
            cnt_p0 <= '0;
        end else if (accept) begin
            if (last) begin
                acc_p0 <= '0;
                cnt_p0 <= '0;
            end else begin
                acc_p0 <= total;
                cnt_p0 <= cnt_base + CW'(1);
            end
        end else if (in_clr) begin
            acc_p0 <= '0;
            cnt_p0 <= '0;
        end
    end

    // Stage p1: registered window total with valid/ready hold
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            out_data_p1 <= '0;
        end else if (last) begin
            vld_p1      <= 1'b1;
            out_data_p1 <= total;
        end else if (vld_p1 && out_ready) begin
            vld_p1      <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = out_data_p1;
    assign out_cnt   = cnt_p0;

endmodule

// File: tb/tb_window_accumulator.sv
// Directed and randomized checks of window_accumulator: a W=4/K=9 instance for
// the directed cases and a W=3/K=4 instance against a sample-sum scoreboard.
module tb_window_accumulator;
    logic clk;
    logic rst;

    logic       in_valid_a, in_ready_a, in_cout_a, in_clr_a;
    logic [3:0] in_sum_a;
    logic       out_valid_a, out_ready_a;
    logic [8:0] out_data_a;
    logic [3:0] out_cnt_a;

    logic       in_valid_b, in_ready_b, in_cout_b, in_clr_b;
    logic [2:0] in_sum_b;
    logic       out_valid_b, out_ready_b;
    logic [5:0] out_data_b;
    logic [2:0] out_cnt_b;

    int checks;
    int failures;

    int qa[$];
    logic ready_drop;

    window_accumulator #(.W(4), .K(9)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_sum(in_sum_a), .in_cout(in_cout_a), .in_clr(in_clr_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_data(out_data_a), .out_cnt(out_cnt_a)
    );

    window_accumulator #(.W(3), .K(4)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_sum(in_sum_b), .in_cout(in_cout_b), .in_clr(in_clr_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_data(out_data_b), .out_cnt(out_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input int val);
        logic [4:0] s;
        s          = 5'(val);
        in_valid_a = v;
        in_cout_a  = s[4];
        in_sum_a   = s[3:0];
    endtask

    task automatic send_a(input int val, input int n);
        for (int i = 0; i < n; i++) begin
            drive_a(1'b1, val);
            tick();
        end
        drive_a(1'b0, 0);
    endtask

    function automatic int qa_at(input int idx);
        if (idx < qa.size()) return qa[idx];
        return -1;
    endfunction

    // Record every drained total of instance A and any stall seen by upstream.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid_a && out_ready_a) qa.push_back(int'(out_data_a));
            if (in_valid_a && !in_ready_a) ready_drop = 1'b1;
        end
    end

    initial begin
        int exp_q[$];
        int got_q[$];
        int m_sum;
        int m_n;
        logic acc_now;
        logic [3:0] s;
        int n;

        checks = 0;
        failures = 0;
        ready_drop = 1'b0;
        rst = 1'b1;
        drive_a(1'b0, 0);
        in_clr_a = 1'b0;
        out_ready_a = 1'b1;
        in_valid_b = 1'b0; in_sum_b = '0; in_cout_b = 1'b0; in_clr_b = 1'b0; out_ready_b = 1'b1;

        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid_a, 0);
        check("rst_out_data", out_data_a, 0);
        check("rst_out_cnt", out_cnt_a, 0);
        check("rst_in_ready", in_ready_a, 1);
        tick();

        // Nine samples of 31
        qa.delete();
        send_a(31, 9);
        @(negedge clk);
        check("max_valid", out_valid_a, 1);
        check("max_data", out_data_a, 279);
        check("max_cnt", out_cnt_a, 0);
        tick();
        @(negedge clk);
        check("max_valid_drop", out_valid_a, 0);
        tick();

        // Back-to-back windows 0..8, 9..17
        qa.delete();
        ready_drop = 1'b0;
        for (int i = 0; i < 18; i++) begin
            drive_a(1'b1, i);
            tick();
        end
        drive_a(1'b0, 0);
        tick(); tick();
        check("b2b_count", qa.size(), 2);
        check("b2b_first", qa_at(0), 36);
        check("b2b_second", qa_at(1), 117);
        check("b2b_no_stall", ready_drop, 0);

        // Backpressure
        qa.delete();
        out_ready_a = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive_a(1'b1, i);
            tick();
        end
        drive_a(1'b1, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready_a, 0);
            check("bp_valid", out_valid_a, 1);
            check("bp_hold", out_data_a, 36);
            check("bp_cnt", out_cnt_a, 0);
            tick();
        end
        out_ready_a = 1'b1;
        @(negedge clk);
        check("bp_release_ready", in_ready_a, 1);
        tick();
        send_a(1, 8);
        tick(); tick();
        check("bp_count", qa.size(), 2);
        check("bp_drained", qa_at(0), 36);
        check("bp_next", qa_at(1), 9);

        // Clear alone
        qa.delete();
        send_a(5, 4);
        @(negedge clk);
        check("clr_pre_cnt", out_cnt_a, 4);
        in_clr_a = 1'b1;
        tick();
        in_clr_a = 1'b0;
        @(negedge clk);
        check("clr_cnt", out_cnt_a, 0);
        tick();
        send_a(2, 9);
        tick(); tick();
        check("clr_count", qa.size(), 1);
        check("clr_total", qa_at(0), 18);

        // Clear together with a sample
        qa.delete();
        send_a(4, 3);
        in_clr_a = 1'b1;
        drive_a(1'b1, 7);
        tick();
        in_clr_a = 1'b0;
        drive_a(1'b0, 0);
        @(negedge clk);
        check("clrs_cnt", out_cnt_a, 1);
        tick();
        send_a(1, 8);
        tick(); tick();
        check("clrs_count", qa.size(), 1);
        check("clrs_total", qa_at(0), 15);

        // Reset with a pending total
        out_ready_a = 1'b0;
        send_a(1, 9);
        @(negedge clk);
        check("rstp_pending", out_valid_a, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rstp_valid", out_valid_a, 0);
        check("rstp_data", out_data_a, 0);
        check("rstp_cnt", out_cnt_a, 0);
        check("rstp_ready", in_ready_a, 1);
        tick();

        // Reset with a partial window
        out_ready_a = 1'b1;
        send_a(2, 5);
        @(negedge clk);
        check("rstw_pre_cnt", out_cnt_a, 5);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rstw_cnt", out_cnt_a, 0);
        check("rstw_valid", out_valid_a, 0);
        tick();
        qa.delete();
        send_a(3, 9);
        tick(); tick();
        check("rstw_count", qa.size(), 1);
        check("rstw_total", qa_at(0), 27);

        // Random traffic on the K=4, W=3 instance
        m_sum = 0;
        m_n = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            check("rnd_ready", in_ready_b, !(out_valid_b && !out_ready_b));
            acc_now = in_valid_b && in_ready_b;
            if (acc_now) begin
                m_sum += int'({in_cout_b, in_sum_b});
                m_n++;
                if (m_n == 4) begin
                    exp_q.push_back(m_sum);
                    m_sum = 0;
                    m_n = 0;
                end
            end
            if (out_valid_b && out_ready_b) got_q.push_back(int'(out_data_b));
            tick();
            if (acc_now || !in_valid_b) begin
                s = 4'($urandom_range(0, 15));
                in_valid_b = ($urandom_range(0, 3) != 0);
                in_cout_b = s[3];
                in_sum_b = s[2:0];
            end
            out_ready_b = ($urandom_range(0, 2) != 0);
        end
        in_valid_b = 1'b0;
        out_ready_b = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (out_valid_b && out_ready_b) got_q.push_back(int'(out_data_b));
            tick();
        end
        check("rnd_enough", exp_q.size() >= 20, 1);
        check("rnd_count", got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check("rnd_total", got_q[i], exp_q[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
